// File: rtl/bitcnt_arbiter.sv
// Two-requester round-robin front end for a shared combinational bit-count unit.
// Latency: grant at T, response valid at T+2; 2 cycles/op back-to-back, 3 from idle.
// Backpressure: rsp_* held stable and no grants issued while rsp_ready is low.

module bitcnt (
  input  logic        mutsel,
  input  logic [63:0] din_data,
  input  logic [2:0]  din_func,
  output logic [63:0] dout_data
);

  logic [63:0] x;
  logic [6:0]  pc;
  logic [6:0]  tz;
  logic [6:0]  lz;
  logic [6:0]  res;
  logic        tz_hit;
  logic        lz_hit;

  // func[2:1]: 00 leading zeros, 01 trailing zeros, 10 popcount; func[0] selects 32-bit form
  always_comb begin
    x = mutsel ? ~din_data : din_data;
    if (din_func[0]) begin
      x[63:32] = '0;
    end
    pc     = '0;
    tz     = '0;
    lz     = '0;
    tz_hit = 1'b0;
    lz_hit = 1'b0;
    for (int i = 0; i < 64; i++) begin
      pc = pc + 7'(x[i]);
      if (!tz_hit && (!din_func[0] || i < 32)) begin
        if (x[i]) begin
          tz_hit = 1'b1;
        end else begin
          tz = tz + 7'd1;
        end
      end
    end
    for (int i = 63; i >= 0; i--) begin
      if (!lz_hit && (!din_func[0] || i < 32)) begin
        if (x[i]) begin
          lz_hit = 1'b1;
        end else begin
          lz = lz + 7'd1;
        end
      end
    end
    case (din_func[2:1])
      2'b00:   res = lz;
      2'b01:   res = tz;
      2'b10:   res = pc;
      default: res = '0;
    endcase
    dout_data = {57'd0, res};
  end

endmodule

module bitcnt_arbiter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [63:0]          req0_data,
  input  logic [2:0]           req0_func,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [63:0]          req1_data,
  input  logic [2:0]           req1_func,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_data,
  output logic                 rsp_id,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        id;
    logic        err;
  } rsp_t;

  state_t      state;
  state_t      state_nxt;
  logic        last;
  logic [63:0] op_data;
  logic [2:0]  op_func;
  logic        op_id;
  rsp_t        rsp_q;
  logic        can_grant;
  logic        gnt0;
  logic        gnt1;
  logic        grant;
  logic [63:0] gnt_data;
  logic [2:0]  gnt_func;
  logic [63:0] bc_dout;
  logic        illegal;

  bitcnt u_bitcnt (
    .mutsel    (1'b0),
    .din_data  (op_data),
    .din_func  (op_func),
    .dout_data (bc_dout)
  );

  // A grant slot opens in IDLE, or in RESP on the cycle the response drains.
  assign can_grant = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign gnt0      = can_grant && req0_valid && (!req1_valid || last);
  assign gnt1      = can_grant && req1_valid && (!req0_valid || !last);
  assign grant     = gnt0 || gnt1;
  assign gnt_data  = gnt1 ? req1_data : req0_data;
  assign gnt_func  = gnt1 ? req1_func : req0_func;
  assign illegal   = (op_func[2:1] == 2'b11);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant ? EXEC : IDLE;
      EXEC:    state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = grant ? EXEC : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
    req0_ready = gnt0;
    req1_ready = gnt1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_data <= '0;
      op_func <= '0;
      op_id   <= 1'b0;
      last    <= 1'b1;
    end else if (grant) begin
      op_data <= gnt_func[0] ? {32'd0, gnt_data[31:0]} : gnt_data;
      op_func <= gnt_func;
      op_id   <= gnt1;
      last    <= gnt1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_q <= '0;
    end else if (state == EXEC) begin
      rsp_q.data <= illegal     ? 64'd0 :
                    op_func[0]  ? {32'd0, bc_dout[31:0]} : bc_dout;
      rsp_q.id   <= op_id;
      rsp_q.err  <= illegal;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_cnt <= '0;
    end else if ((state == RESP) && rsp_ready && (done_cnt != {CNT_WIDTH{1'b1}})) begin
      done_cnt <= done_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign rsp_data = rsp_q.data;
  assign rsp_id   = rsp_q.id;
  assign rsp_err  = rsp_q.err;

endmodule

// File: tb/tb_bitcnt_arbiter.sv
// Bench for bitcnt_arbiter: randomized ops checked against a loop-based bit-count model.
module tb_bitcnt_arbiter;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0]   req0_data, req1_data, rsp_data;
  logic [2:0]    req0_func, req1_func;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [CW-1:0] done_cnt;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int exp_done = 0;

  bitcnt_arbiter #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_func(req1_func),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] ref_result(input logic [2:0] f, input logic [63:0] d);
    logic [63:0] v;
    int n, k;
    if (f[2:1] == 2'b11) return 64'd0;
    n = f[0] ? 32 : 64;
    v = f[0] ? {32'd0, d[31:0]} : d;
    k = 0;
    case (f[2:1])
      2'b00:   while (k < n && v[n-1-k] == 1'b0) k++;
      2'b01:   while (k < n && v[k] == 1'b0) k++;
      default: for (int i = 0; i < n; i++) k += int'(v[i]);
    endcase
    return 64'(k);
  endfunction

  function automatic logic [63:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 4))
      0: r = r >> $urandom_range(0, 63);
      1: r = r << $urandom_range(0, 63);
      2: r = 64'd0;
      default: ;
    endcase
    return r;
  endfunction

  task automatic bump_done();
    exp_done = (exp_done == (1 << CW) - 1) ? exp_done : exp_done + 1;
  endtask

  task automatic do_op(input bit id, input logic [63:0] d, input logic [2:0] f, input string nm);
    int gc, lat;
    bit got;
    logic [63:0] exp_d;
    exp_d = ref_result(f, d);
    @(negedge clk);
    if (id) begin req1_valid = 1; req1_data = d; req1_func = f; end
    else    begin req0_valid = 1; req0_data = d; req0_func = f; end
    got = 0; gc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin got = 1; gc = cyc; end
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_grant: ready never seen within 20 cycles", nm);
      req0_valid = 0; req1_valid = 0;
      return;
    end
    checks++;
    if ((id ? req0_ready : req1_ready) !== 1'b0) begin
      errors++; $display("FAIL %s_other_ready: got 1 want 0", nm);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (rsp_valid === 1'b1) got = 1;
      else @(negedge clk);
    end
    lat = cyc - gc;
    checks++;
    if (!got || lat != 2) begin errors++; $display("FAIL %s_latency: got %0d want 2 (seen=%0d)", nm, lat, got); end
    checks++;
    if (rsp_data !== exp_d) begin errors++; $display("FAIL %s_data: got %h want %h (func=%0d d=%h)", nm, rsp_data, exp_d, f, d); end
    checks++;
    if (rsp_id !== id) begin errors++; $display("FAIL %s_id: got %0d want %0d", nm, rsp_id, id); end
    checks++;
    if (rsp_err !== (f[2:1] == 2'b11)) begin errors++; $display("FAIL %s_err: got %0d want %0d", nm, rsp_err, f[2:1] == 2'b11); end
    bump_done();
    @(negedge clk);
    #1;
    checks++;
    if (done_cnt !== CW'(exp_done)) begin errors++; $display("FAIL %s_done_cnt: got %0d want %0d", nm, done_cnt, exp_done); end
  endtask

  task automatic test_reset();
    resetn = 0; rsp_ready = 1;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0; req0_func = '0; req1_func = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready} !== 6'b0 || rsp_data !== 64'd0 || done_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0d id=%0d err=%0d busy=%0d rdy=%0d%0d data=%h cnt=%0d want all 0",
               rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready, rsp_data, done_cnt);
    end
    @(negedge clk);
    resetn = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0 || done_cnt !== '0) begin
      errors++; $display("FAIL reset_release_idle: got v=%0d busy=%0d cnt=%0d want 0", rsp_valid, busy, done_cnt);
    end
  endtask

  task automatic test_single_64();
    do_op(0, 64'h0123_4567_89AB_CDEF, 3'd0, "single64");
  endtask

  task automatic test_mask32();
    do_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, "mask32_clzw");
    do_op(1, 64'hFFFF_FFFF_0000_0000, 3'd3, "mask32_ctzw_zero");
    do_op(0, 64'hAAAA_5555_F0F0_0001, 3'd5, "mask32_pcntw");
  endtask

  task automatic test_illegal();
    do_op(0, 64'hDEAD_BEEF_CAFE_F00D, 3'd6, "illegal6");
    do_op(0, 64'h1, 3'd7, "illegal7");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      do_op(1'($urandom_range(0, 1)), rand_data(), 3'($urandom_range(0, 7)), "random");
    end
  endtask

  task automatic test_contention();
    logic [63:0] d0, d1;
    logic [2:0]  f0, f1;
    bit          g0, g1;
    int          ng, nr, last_rc;
    int          gids[$];
    logic [63:0] q_data[$];
    logic        q_id[$];
    logic [63:0] ed;
    logic        eid;
    do_op(1, 64'h8000_0000_0000_0000, 3'd0, "contention_prime");
    ng = 0; nr = 0; last_rc = -1;
    d0 = rand_data(); f0 = 3'($urandom_range(0, 5));
    d1 = rand_data(); f1 = 3'($urandom_range(0, 5));
    @(negedge clk);
    req0_valid = 1; req0_data = d0; req0_func = f0;
    req1_valid = 1; req1_data = d1; req1_func = f1;
    for (int c = 0; c < 60 && nr < 4; c++) begin
      #1;
      g0 = req0_ready; g1 = req1_ready;
      checks++;
      if (g0 && g1) begin errors++; $display("FAIL contention_both_ready: got both ready at cycle %0d", cyc); end
      if (rsp_valid === 1'b1) begin
        checks++;
        if (q_id.size() == 0) begin
          errors++; $display("FAIL contention_rsp_unexpected: got response with nothing issued");
        end else begin
          ed = q_data.pop_front(); eid = q_id.pop_front();
          if (rsp_data !== ed || rsp_id !== eid) begin
            errors++; $display("FAIL contention_rsp: got id=%0d data=%h want id=%0d data=%h", rsp_id, rsp_data, eid, ed);
          end
        end
        if (last_rc >= 0) begin
          checks++;
          if (cyc - last_rc != 2) begin errors++; $display("FAIL contention_spacing: got %0d cycles want 2", cyc - last_rc); end
        end
        last_rc = cyc; nr++;
        bump_done();
      end
      if (g0) begin q_data.push_back(ref_result(f0, d0)); q_id.push_back(0); gids.push_back(0); ng++; end
      if (g1) begin q_data.push_back(ref_result(f1, d1)); q_id.push_back(1); gids.push_back(1); ng++; end
      @(negedge clk);
      if (g0) begin d0 = rand_data(); f0 = 3'($urandom_range(0, 5)); req0_data = d0; req0_func = f0; end
      if (g1) begin d1 = rand_data(); f1 = 3'($urandom_range(0, 5)); req1_data = d1; req1_func = f1; end
      if (ng >= 4) begin req0_valid = 0; req1_valid = 0; end
    end
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (nr != 4 || gids.size() != 4) begin
      errors++; $display("FAIL contention_count: got %0d responses %0d grants want 4 and 4", nr, gids.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gids[i] != i % 2) begin errors++; $display("FAIL contention_order: grant %0d got id %0d want %0d", i, gids[i], i % 2); end
      end
    end
    #1;
    checks++;
    if (done_cnt !== CW'(exp_done)) begin errors++; $display("FAIL contention_done_cnt: got %0d want %0d", done_cnt, exp_done); end
  endtask

  task automatic test_backpressure();
    logic [63:0] d0, d1, s_data;
    logic [2:0]  f0, f1;
    logic        s_id, s_err;
    bit          got;
    d0 = rand_data(); f0 = 3'd4;
    d1 = rand_data(); f1 = 3'd2;
    @(negedge clk);
    rsp_ready = 0;
    req0_valid = 1; req0_data = d0; req0_func = f0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin #1; if (req0_ready === 1'b1) got = 1; else @(negedge clk); end
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_data = d1; req1_func = f1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin #1; if (rsp_valid === 1'b1) got = 1; else @(negedge clk); end
    s_data = rsp_data; s_id = rsp_id; s_err = rsp_err;
    checks++;
    if (!got || s_data !== ref_result(f0, d0) || s_id !== 1'b0 || s_err !== 1'b0) begin
      errors++; $display("FAIL bp_first_rsp: got v=%0d id=%0d data=%h want id=0 data=%h", got, s_id, s_data, ref_result(f0, d0));
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== s_data || rsp_id !== s_id || rsp_err !== s_err || req1_ready !== 1'b0 || done_cnt !== CW'(exp_done)) begin
        errors++; $display("FAIL bp_hold: cycle %0d got v=%0d data=%h rdy1=%0d cnt=%0d want v=1 data=%h rdy1=0 cnt=%0d",
                           c, rsp_valid, rsp_data, req1_ready, done_cnt, s_data, exp_done);
      end
    end
    @(negedge clk);
    rsp_ready = 1;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL bp_release_grant: got rdy0=%0d rdy1=%0d want 0 1", req0_ready, req1_ready);
    end
    bump_done();
    @(negedge clk);
    req1_valid = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin #1; if (rsp_valid === 1'b1) got = 1; else @(negedge clk); end
    checks++;
    if (!got || rsp_data !== ref_result(f1, d1) || rsp_id !== 1'b1) begin
      errors++; $display("FAIL bp_second_rsp: got v=%0d id=%0d data=%h want id=1 data=%h", got, rsp_id, rsp_data, ref_result(f1, d1));
    end
    bump_done();
    @(negedge clk);
    #1;
    checks++;
    if (done_cnt !== CW'(exp_done)) begin errors++; $display("FAIL bp_done_cnt: got %0d want %0d", done_cnt, exp_done); end
  endtask

  task automatic test_reset_mid_op();
    bit got, seen;
    @(negedge clk);
    req0_valid = 1; req0_data = 64'h0F; req0_func = 3'd4;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin #1; if (req0_ready === 1'b1) got = 1; else @(negedge clk); end
    @(negedge clk);
    req0_valid = 0;
    #1;
    checks++;
    if (!got || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_exec: got grant=%0d busy=%0d v=%0d want 1 1 0", got, busy, rsp_valid);
    end
    resetn = 0;
    exp_done = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready} !== 6'b0 || rsp_data !== 64'd0 || done_cnt !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got v=%0d busy=%0d data=%h cnt=%0d want all 0", rsp_valid, busy, rsp_data, done_cnt);
    end
    @(negedge clk);
    resetn = 1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_mid_no_rsp: got a response or busy after reset want none"); end
    @(negedge clk);
    req0_valid = 1; req0_data = 64'h3; req0_func = 3'd4;
    req1_valid = 1; req1_data = 64'h7; req1_func = 3'd4;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_first_grant: got rdy0=%0d rdy1=%0d want 1 0", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin #1; if (rsp_valid === 1'b1) got = 1; else @(negedge clk); end
    checks++;
    if (!got || rsp_id !== 1'b0 || rsp_data !== 64'd2) begin
      errors++; $display("FAIL rst_mid_after_rsp: got v=%0d id=%0d data=%h want id=0 data=2", got, rsp_id, rsp_data);
    end
    bump_done();
    @(negedge clk);
    #1;
    checks++;
    if (done_cnt !== CW'(exp_done)) begin errors++; $display("FAIL rst_mid_done_cnt: got %0d want %0d", done_cnt, exp_done); end
  endtask

  initial begin
    test_reset();
    test_single_64();
    test_mask32();
    test_illegal();
    test_random();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitcnt_arbiter.md
# bitcnt_arbiter

Shares a single `bitcnt` datapath instance between two requesters. Each requester issues operand/opcode pairs over a valid/ready port. The block arbitrates round-robin, sequences each operation through a registered issue/capture pipeline, and returns the result on one valid/ready response port tagged with the requester id. It sits between instruction-issue logic (two lanes) and the bit-count unit, and owns all opcode legality and width masking for that unit.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of the completed-operation counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `req0_valid`  in  1: requester 0 has an operation.
- `req0_ready`  out  1: requester 0 operation accepted this cycle.
- `req0_data`  in  64: requester 0 operand.
- `req0_func`  in  3: requester 0 opcode.
- `req1_valid`, `req1_ready`, `req1_data`, `req1_func`: same as requester 0, for requester 1.
- `rsp_valid`  out  1: response available.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_data`  out  64: result.
- `rsp_id`  out  1: requester that issued the operation.
- `rsp_err`  out  1: opcode was illegal (6 or 7).
- `busy`  out  1: an operation is in EXEC or RESP.
- `done_cnt`  out  CNT_WIDTH: count of completed responses (saturating).

## Operation
- One internal `bitcnt` instance. `mutsel` is tied to 0. Its inputs `din_data` and `din_func` are driven from the operand registers `op_data` and `op_func`.
- Opcode rules:
  - `func[0]`=1 is a 32-bit op. Only `data[31:0]` is meaningful. `op_data[63:32]` is forced to 0 at capture. `rsp_data[63:32]` is forced to 0.
  - `func[0]`=0 is a 64-bit op. All 64 bits are used.
  - `func`=3'b110 and 3'b111 are illegal. They still take the normal path, return `rsp_err`=1 and `rsp_data`=0.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any `reqN_valid`, grant one requester (see arbitration) with `reqN_ready`=1 combinationally. Capture `op_data`, `op_func` and `op_id`, then go to EXEC. Otherwise stay in IDLE.
  - EXEC: register the `bitcnt` `dout_data` (masked per the opcode rules) into `rsp_data`. Set `rsp_err` and `rsp_id`. Go to RESP.
  - RESP: `rsp_valid`=1, with `rsp_data`, `rsp_id` and `rsp_err` held stable.
    - On `rsp_ready`, increment `done_cnt` (saturating at all-ones).
    - On `rsp_ready` with a request pending, grant it in the same cycle and go to EXEC.
    - On `rsp_ready` with no request pending, go to IDLE.
    - Without `rsp_ready`, stay in RESP with no grant.
- Arbitration:
  - Round-robin pointer `last` records the last granted id. Reset value is 1, so requester 0 wins the first contention.
  - Only one requester is granted. A lone requester is always granted.
  - When both request, the one with id != `last` wins.
  - `last` updates only on an actual grant.
- `reqN_ready` is never asserted outside a grant cycle, and never to both requesters at once. It does not depend on the non-granted requester's inputs.
- Requester rule: `valid`, `data` and `func` stay stable until `ready`. The block does not check this.
- `busy` = (state != IDLE).

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, `last`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0, `done_cnt`=0, `busy`=0, both `ready`=0. `op_*` registers clear to 0.
- Reset mid-operation: the in-flight op is discarded and no response is produced.
- Latency: a grant at cycle T gives state EXEC at T+1 and `rsp_valid`=1 at T+2.
- Throughput:
  - Back-to-back with `rsp_ready` held at 1: one op per 2 cycles (RESP goes directly to EXEC).
  - From IDLE: 3 cycles per op.
- Backpressure: `rsp_valid` stays 1 and all `rsp_*` stay stable until `rsp_ready`. No new grants occur during backpressure.
- The `bitcnt` path is combinational between `op_*` and the EXEC capture register. It must close timing in one cycle.

## Test plan
- Single op, 64-bit: `req0`, data=64'h0123_4567_89AB_CDEF, func=0, `rsp_ready`=1. Expect `req0_ready` at T, `rsp_valid` at T+2, `rsp_data` equal to `bitcnt(0, data, 0)`, `rsp_id`=0, `rsp_err`=0, `done_cnt`=1.
- 32-bit masking: `req1`, data=64'hFFFF_FFFF_FFFF_FFFF, func=1. Expect `rsp_data[63:32]`=0, `rsp_data[31:0]` = `bitcnt(0, 64'h0000_0000_FFFF_FFFF, 1)[31:0]`, `rsp_id`=1.
- Illegal opcode: `req0`, func=6, then func=7, any data. Expect `rsp_err`=1, `rsp_data`=0, latency 2, `done_cnt` incremented.
- Contention: both valid continuously for 4 ops with `rsp_ready`=1. Grants must be 0,1,0,1; `rsp_valid` every 2 cycles after the first; never both `ready`.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP with `req1_valid`=1. Expect `rsp_*` stable, `req1_ready`=0 throughout, then a grant to `req1` in the cycle `rsp_ready` rises.
- Reset mid-op: assert `resetn`=0 in EXEC. Expect all outputs at reset values immediately, no `rsp_valid` after release, and the next contention granted to requester 0.
